// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage in front of the control-unit decoder. It holds the fetch PC,
// sends word fetches to instruction memory and registers each returned
// instruction for decode. Redirects from branch/jump resolution replace the
// fetch PC. A fetch that was already sent when a redirect arrives is marked
// wrong-path, and its response is discarded.
//
// Handshakes:
//   Memory request:  the request transfers on a cycle with
//                    imem_req_valid && imem_req_ready. Only one request is
//                    outstanding. A request that has not been accepted can be
//                    withdrawn or re-addressed.
//   Memory response: imem_rsp_valid marks a cycle that carries data for the
//                    outstanding request. It is ignored when no request is
//                    outstanding.
//   Decode output:   the held instruction is consumed on a cycle with
//                    if_valid && !stall. The outputs do not change while
//                    stall=1, except that a redirect flushes them.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req_valid/addr      fetch request and its word-aligned byte address
//   imem_req_ready           memory accepts the request this cycle
//   imem_rsp_valid/data      response strobe and the fetched word
//   redirect_valid/pc        redirect the fetch stream to redirect_pc
//   stall                    decode cannot accept the held instruction
//   if_valid/instr/pc        held instruction and its address
//   if_pc_plus4              link value (if_pc + 4)
//   opcode..jidx             field slices of if_instr
//   dbg_state                current FSM state (0 = REQ, 1 = WAIT)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jidx,
    output logic        dbg_state
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // The reset PC is always word aligned.
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic        drop, drop_nxt;
    logic        if_valid_nxt;
    logic [31:0] if_instr_nxt, if_pc_nxt, if_pc_plus4_nxt;

    logic        req_fire;
    logic        consume;
    logic [31:0] redirect_pc_w;
    logic        redirect_lsb_unused;

    // Redirect targets are forced to word alignment. The low bits are
    // deliberately left unused.
    assign redirect_pc_w       = {redirect_pc[31:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // A request is offered only when the output slot is free or is being
    // drained this cycle. This keeps the single-entry output register from
    // overflowing. The request is gated off while reset is asserted.
    assign imem_req_valid = rst_n && (state == S_REQ) && (!if_valid || !stall);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign consume        = if_valid && !stall;

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        drop_nxt        = drop;
        if_valid_nxt    = if_valid;
        if_instr_nxt    = if_instr;
        if_pc_nxt       = if_pc;
        if_pc_plus4_nxt = if_pc_plus4;

        if (redirect_valid) begin
            // A redirect flushes the held instruction even under stall.
            fetch_pc_nxt    = redirect_pc_w;
            if_valid_nxt    = 1'b0;
            if_instr_nxt    = '0;
            if_pc_nxt       = '0;
            if_pc_plus4_nxt = '0;
            if (state == S_WAIT) begin
                if (imem_rsp_valid) begin
                    // The old-path fetch completes in this cycle and its data
                    // is discarded, so no request is left to drop.
                    state_nxt = S_REQ;
                    drop_nxt  = 1'b0;
                end else begin
                    state_nxt = S_WAIT;
                    drop_nxt  = 1'b1;
                end
            end else if (req_fire) begin
                // The request accepted now used the old address.
                state_nxt = S_WAIT;
                drop_nxt  = 1'b1;
            end else begin
                // Nothing was accepted. The request is re-issued at the new
                // address on the next cycle.
                state_nxt = S_REQ;
            end
        end else begin
            if (consume) begin
                if_valid_nxt = 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_nxt = S_REQ;
                        if (drop) begin
                            // fetch_pc already holds the redirect target.
                            drop_nxt = 1'b0;
                        end else begin
                            if_valid_nxt    = 1'b1;
                            if_instr_nxt    = imem_rsp_data;
                            if_pc_nxt       = fetch_pc;
                            if_pc_plus4_nxt = fetch_pc + 32'd4;
                            fetch_pc_nxt    = fetch_pc + 32'd4;
                        end
                    end
                end
                default: begin
                    state_nxt = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC_W;
            drop        <= 1'b0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            drop        <= drop_nxt;
            if_valid    <= if_valid_nxt;
            if_instr    <= if_instr_nxt;
            if_pc       <= if_pc_nxt;
            if_pc_plus4 <= if_pc_plus4_nxt;
        end
    end

    // The field outputs are plain slices of the instruction register. Decode
    // must qualify them with if_valid.
    assign opcode = if_instr[31:26];
    assign rs     = if_instr[25:21];
    assign rt     = if_instr[20:16];
    assign rd     = if_instr[15:11];
    assign funct  = if_instr[5:0];
    assign imm16  = if_instr[15:0];
    assign jidx   = if_instr[25:0];

    assign dbg_state = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Part 1: a table of directed cycles covering the basic fetches, stall,
//         redirects and PC wrap.
// Part 2: a hand-written check of asynchronous reset in the middle of a fetch.
// Part 3: random traffic. A memory responder with random latency drives the
//         DUT. An instruction-stream reference model tracks the program-order
//         PC, the outstanding fetch (and whether it is wrong-path) and the
//         expected held instruction.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic        dbg_state;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
        .imm16(imm16), .jidx(jidx), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_if(input string tag, input logic ev, input logic [31:0] ei,
                            input logic [31:0] ep, input logic [31:0] ep4);
        check({tag, ".if_valid"},    32'(if_valid), 32'(ev));
        check({tag, ".if_instr"},    if_instr, ei);
        check({tag, ".if_pc"},       if_pc, ep);
        check({tag, ".if_pc_plus4"}, if_pc_plus4, ep4);
        check({tag, ".opcode"},      32'(opcode), 32'(ei[31:26]));
        check({tag, ".rs"},          32'(rs),     32'(ei[25:21]));
        check({tag, ".rt"},          32'(rt),     32'(ei[20:16]));
        check({tag, ".rd"},          32'(rd),     32'(ei[15:11]));
        check({tag, ".funct"},       32'(funct),  32'(ei[5:0]));
        check({tag, ".imm16"},       32'(imm16),  32'(ei[15:0]));
        check({tag, ".jidx"},        32'(jidx),   32'(ei[25:0]));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        redir;
        logic [31:0] redir_pc;
        logic        stall;
        logic        e_req_valid;
        logic [31:0] e_req_addr;
        logic        e_if_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdat,
                                input logic rdr, input logic [31:0] rpc, input logic stl,
                                input logic erv, input logic [31:0] era,
                                input logic eiv, input logic [31:0] ei,
                                input logic [31:0] ep, input logic [31:0] ep4);
        vec_t v;
        v.ready = rdy; v.rsp_valid = rv; v.rsp_data = rdat;
        v.redir = rdr; v.redir_pc = rpc; v.stall = stl;
        v.e_req_valid = erv; v.e_req_addr = era;
        v.e_if_valid = eiv; v.e_instr = ei; v.e_pc = ep; v.e_pc4 = ep4;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        imem_req_ready = v.ready;
        imem_rsp_valid = v.rsp_valid;
        imem_rsp_data  = v.rsp_data;
        redirect_valid = v.redir;
        redirect_pc    = v.redir_pc;
        stall          = v.stall;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
    endtask

    // Memory contents for the random phase: a fixed scramble of the address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- reference model state (random phase) ----------------
    logic [31:0] exp_q[$];      // expected held instruction (its PC)
    logic [31:0] next_pc;       // program-order address of the next good fetch
    logic        pending;       // a request is outstanding at the memory
    logic        pend_stale;    // that request is wrong-path
    logic [31:0] pend_addr;
    int          mem_dly;
    int          delivered;

    localparam logic [31:0] W0   = 32'h2008_0005;  // addi $t0,$zero,5
    localparam logic [31:0] W1   = 32'h8D09_0004;  // lw $t1,4($t0)
    localparam logic [31:0] W2   = 32'h0085_1020;  // add
    localparam logic [31:0] W100 = 32'h3C01_1234;  // lui
    localparam logic [31:0] W200 = 32'h2222_2222;
    localparam logic [31:0] WFC  = 32'h0800_0040;  // j
    localparam logic [31:0] W40  = 32'hAC0A_0008;  // sw

    initial begin
        logic        rsp_now, accept, consume, redir;
        logic [31:0] target, hp;

        idle_inputs();
        #1 rst_n = 1'b0;

        // Per-cycle rows: inputs for the cycle, outputs expected in that cycle.
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0,         0, 32'h0, 32'h0,   32'h0));
        tbl.push_back(mk(1, 1, W0,            0, 32'h0,         0, 0, 32'h0,         0, 32'h0, 32'h0,   32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h4,         1, W0,    32'h0,   32'h4));
        tbl.push_back(mk(1, 1, W1,            0, 32'h0,         0, 0, 32'h4,         0, W0,    32'h0,   32'h4));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 32'h0,     0, 32'h0,         1, 0, 32'h8,         1, W1,    32'h4,   32'h8));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8,         1, W1,    32'h4,   32'h8));
        tbl.push_back(mk(1, 1, W2,            0, 32'h0,         0, 0, 32'h8,         0, W1,    32'h4,   32'h8));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'hC,         1, W2,    32'h8,   32'hC));
        // redirect to 0x103 while waiting; the 0xC response is dropped
        tbl.push_back(mk(1, 0, 32'h0,         1, 32'h103,       0, 0, 32'hC,         0, W2,    32'h8,   32'hC));
        tbl.push_back(mk(1, 1, 32'hDEAD_BEEF, 0, 32'h0,         0, 0, 32'h100,       0, 32'h0, 32'h0,   32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h100,       0, 32'h0, 32'h0,   32'h0));
        tbl.push_back(mk(1, 1, W100,          0, 32'h0,         0, 0, 32'h100,       0, 32'h0, 32'h0,   32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h104,       1, W100,  32'h100, 32'h104));
        // redirect in the same cycle as a response
        tbl.push_back(mk(1, 1, 32'h1111_1111, 1, 32'h200,       0, 0, 32'h104,       0, W100,  32'h100, 32'h104));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h200,       0, 32'h0, 32'h0,   32'h0));
        tbl.push_back(mk(1, 1, W200,          0, 32'h0,         0, 0, 32'h200,       0, 32'h0, 32'h0,   32'h0));
        // redirect to the top word while a request is accepted in the same cycle
        tbl.push_back(mk(1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 1, 32'h204,       1, W200,  32'h200, 32'h204));
        tbl.push_back(mk(1, 1, 32'h3333_3333, 0, 32'h0,         0, 0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0,   32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0,   32'h0));
        tbl.push_back(mk(1, 1, WFC,           0, 32'h0,         0, 0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0,   32'h0));
        // PC wraps; a spurious response in REQ is ignored
        tbl.push_back(mk(0, 1, 32'h5555_5555, 0, 32'h0,         0, 1, 32'h0,         1, WFC,   32'hFFFF_FFFC, 32'h0));
        // redirect in REQ with no acceptance
        tbl.push_back(mk(0, 0, 32'h0,         1, 32'h40,        0, 1, 32'h0,         0, WFC,   32'hFFFF_FFFC, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h40,        0, 32'h0, 32'h0,   32'h0));
        tbl.push_back(mk(1, 1, W40,           0, 32'h0,         0, 0, 32'h40,        0, 32'h0, 32'h0,   32'h0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h44,        1, W40,   32'h40,  32'h44));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h44,        0, W40,   32'h40,  32'h44));

        // ---- reset values ----
        @(negedge clk);
        #1;
        check("reset.req_valid", 32'(imem_req_valid), 32'h0);
        check("reset.req_addr", imem_req_addr, RESET_PC);
        check_if("reset", 1'b0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // ---- directed table ----
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("row%0d.req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_req_valid));
            check($sformatf("row%0d.req_addr", i), imem_req_addr, tbl[i].e_req_addr);
            check_if($sformatf("row%0d", i), tbl[i].e_if_valid, tbl[i].e_instr,
                     tbl[i].e_pc, tbl[i].e_pc4);
        end

        // ---- asynchronous reset while waiting on a fetch of 0x44 ----
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("areset.req_valid", 32'(imem_req_valid), 32'h0);
        check("areset.req_addr", imem_req_addr, RESET_PC);
        check_if("areset", 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("post_reset%0d.req_valid", i), 32'(imem_req_valid), 32'h1);
            check($sformatf("post_reset%0d.req_addr", i), imem_req_addr, RESET_PC);
            check($sformatf("post_reset%0d.if_valid", i), 32'(if_valid), 32'h0);
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        #1 check("post_reset.accept_valid", 32'(imem_req_valid), 32'h1);
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = W0;
        #1 check("post_reset.wait_valid", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        #1 check_if("post_reset.deliver", 1'b1, W0, RESET_PC, RESET_PC + 32'd4);

        // ---- random traffic against the stream model ----
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        exp_q.delete();
        next_pc    = RESET_PC;
        pending    = 1'b0;
        pend_stale = 1'b0;
        pend_addr  = '0;
        mem_dly    = 0;
        delivered  = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rsp_now = 1'b0;
            imem_rsp_data = $urandom;
            if (pending && mem_dly == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word(pend_addr);
                rsp_now        = 1'b1;
            end else if (!pending && $urandom_range(0, 9) == 0) begin
                imem_rsp_valid = 1'b1;
            end else begin
                imem_rsp_valid = 1'b0;
            end
            imem_req_ready = ($urandom_range(0, 3) != 0);
            stall          = ($urandom_range(0, 2) == 0);
            redir          = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       target = $urandom;
                1:       target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: target = 32'($urandom_range(0, 255));
            endcase
            redirect_valid = redir;
            redirect_pc    = target;
            #1;

            check("rnd.req_valid", 32'(imem_req_valid),
                  32'(!pending && (exp_q.size() == 0 || !stall)));
            if (imem_req_valid)
                check("rnd.req_addr", imem_req_addr, next_pc);
            if (exp_q.size() != 0) begin
                hp = exp_q[0];
                check_if("rnd", 1'b1, word(hp), hp, hp + 32'd4);
            end else begin
                check("rnd.if_valid", 32'(if_valid), 32'h0);
            end

            // advance the model across the coming edge
            accept  = imem_req_valid && imem_req_ready;
            consume = (exp_q.size() != 0) && !stall;
            if (redir) begin
                exp_q.delete();
            end else begin
                if (consume) void'(exp_q.pop_front());
                if (rsp_now && !pend_stale) begin
                    exp_q.push_back(pend_addr);
                    delivered++;
                end
            end
            if (pending && !rsp_now) begin
                if (mem_dly > 0) mem_dly--;
                if (redir) pend_stale = 1'b1;
            end
            if (rsp_now) pending = 1'b0;
            if (accept) begin
                pending    = 1'b1;
                pend_addr  = imem_req_addr;
                pend_stale = redir;
                mem_dly    = $urandom_range(0, 2);
            end
            if (redir)       next_pc = {target[31:2], 2'b00};
            else if (accept) next_pc = next_pc + 32'd4;
        end
        check("rnd.progress", 32'(delivered > 100), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control-unit decoder: holds the PC, issues word fetches to instruction memory over a request/response handshake and registers the returned instruction.
- Presents the instruction and its decoded field slices (opcode, funct, rs, rt, rd, imm16, jump index) to decode, with one valid/stall handshake.
- Accepts PC redirects from branch/jump resolution and discards wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] treated as 0.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch byte address, word-aligned
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  fetched instruction word
- redirect_valid  in  1  take redirect_pc this cycle (branch taken / jump)
- redirect_pc  in  32  new fetch address
- stall  in  1  decode cannot accept the held instruction
- if_valid  out  1  if_instr/if_pc hold a valid instruction
- if_instr  out  32  registered instruction
- if_pc  out  32  address of if_instr
- if_pc_plus4  out  32  if_pc + 4, link value for JAL
- opcode  out  6  if_instr[31:26]
- rs  out  5  if_instr[25:21]
- rt  out  5  if_instr[20:16]
- rd  out  5  if_instr[15:11]
- funct  out  6  if_instr[5:0]
- imm16  out  16  if_instr[15:0]
- jidx  out  26  if_instr[25:0]

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, state=REQ, drop=0.
  - if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0.
  - imem_req_valid=0 while rst_n=0.
  - imem_req_addr = fetch_pc.
- Field outputs are pure slices of the if_instr register. They are 0 after reset/flush. Decode must qualify them with if_valid.
- State REQ:
  - imem_req_valid = !if_valid || !stall. Output slot is free or drains this cycle.
  - imem_req_addr = fetch_pc.
  - On imem_req_valid && imem_req_ready, go to WAIT.
- State WAIT:
  - imem_req_valid=0. At most one request is outstanding.
  - On imem_rsp_valid with drop=0: if_instr <= rsp_data, if_pc <= fetch_pc, if_pc_plus4 <= fetch_pc+4, if_valid <= 1, fetch_pc <= fetch_pc+4, go to REQ.
  - On imem_rsp_valid with drop=1: discard data, drop <= 0, go to REQ. fetch_pc already holds the redirect target.
- Latency: request accepted in cycle N, response in cycle N+k (k>=1), if_valid high at edge N+k+1. Back-to-back throughput is 1 instruction per 2 cycles with k=1.
- Output handshake:
  - Instruction is consumed on any cycle with if_valid && !stall.
  - if_valid clears on consume unless a new response loads the same edge.
  - Outputs stay stable while stall=1.
- Redirect (highest priority, any state):
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - if_valid <= 0 (flush held instruction, even if stall=1).
  - In WAIT, or in REQ with the request accepted the same cycle: drop <= 1, state=WAIT.
  - A response arriving in the same cycle as a redirect is discarded. drop stays 0 for that cycle if the request completed.
  - In REQ with no acceptance: state stays REQ and the address changes next cycle. The memory interface permits abandoning an unaccepted request.
- fetch_pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Reset mid-fetch: outstanding response is ignored. State returns to REQ at RESET_PC after rst_n rises. Memory must not hold a response across reset.
- imem_rsp_valid in REQ (spurious) is ignored.

Test Plan:
- Reset release, RESET_PC=0, memory ready=1 with 1-cycle response, words 0x20080005 and 0x8D090004:
  - imem_req_addr 0x0 then 0x4.
  - if_valid with if_instr=0x20080005, opcode=8, rt=8, imm16=5, if_pc=0, if_pc_plus4=4.
  - Next instruction opcode=35 at if_pc=4.
- stall=1 for 5 cycles while if_valid=1:
  - if_instr/if_pc unchanged.
  - imem_req_valid=0.
  - Fetch of next word resumes the cycle stall drops.
- Redirect to 0x0000_0103 while in WAIT:
  - Pending response discarded, if_valid=0.
  - Next request address is 0x100.
  - First delivered if_pc=0x100.
- Redirect asserted in the same cycle as imem_rsp_valid:
  - Response not delivered.
  - Next request at redirect target.
- PC wrap: redirect to 0xFFFF_FFFC:
  - Delivered if_pc=0xFFFF_FFFC, if_pc_plus4=0.
  - Following request address 0x0.
- rst_n pulsed low during WAIT with imem_req_ready held 0 afterwards:
  - Outputs zero immediately (async).
  - After release, imem_req_valid=1 with addr=RESET_PC, held stable until ready.
